// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and constants for the frequency meter.
//   state_t     : measurement FSM states (IDLE, SETTLE, GATE, DONE)
//   AVG_WINDOWS : number of windows averaged when FREQ_METER_AVG_EN is defined
//   AVG_SHIFT   : log2(AVG_WINDOWS), used for the divide-by-4 of the average
// -----------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int AVG_WINDOWS = 4;
  localparam int AVG_SHIFT   = $clog2(AVG_WINDOWS);

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous input into the clk_i domain through SYNC_STAGES
// flops and flags its rising edges.
//   clk_i  : reference clock
//   rst_i  : synchronous active-high reset, clears every flop
//   sig_i  : asynchronous input
//   rise_o : one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_i};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Rise is taken from the last synchronizer stage against its delayed copy.
  assign rise_o = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Counts rising edges of an asynchronous square wave over a gate window of
// GATE_CYCLES reference cycles and reports the count as a frequency code.
//   clk_i        : reference clock (only clock of the block)
//   rst_i        : synchronous active-high reset
//   sig_i        : asynchronous signal under measurement
//   start_i      : one-cycle start request, honoured only in IDLE
//   continuous_i : sampled in DONE; high repeats windows back-to-back
//   busy_o       : high while a measurement is in progress
//   count_o      : result of the last completed measurement
//   valid_o      : one-cycle pulse when count_o/overflow_o update
//   overflow_o   : the edge counter saturated during the measurement
// Optional feature macro FREQ_METER_AVG_EN: each result is the floor of the
// mean of four consecutive windows; a single start runs four windows.
// -----------------------------------------------------------------------------
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sig_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   valid_o,
  output logic                   overflow_o
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [GW-1:0]          GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]          SETTLE_LAST = SW'(SYNC_STAGES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

  state_t                 state_reg;
  logic [SW-1:0]          settle_cnt_reg;
  logic [GW-1:0]          gate_cnt_reg;
  logic [COUNT_WIDTH-1:0] edge_cnt_reg, edge_cnt_next;
  logic                   sat_reg, sat_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   overflow_reg;
  logic                   valid_reg;
  logic                   busy_reg;
  logic                   rise;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (sig_i),
    .rise_o (rise)
  );

  // Edge counter including the current cycle's edge, so the last gate cycle
  // is counted when the result is captured on the GATE -> DONE transition.
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    sat_next      = sat_reg;
    if (rise) begin
      if (edge_cnt_reg == COUNT_MAX) sat_next = 1'b1;
      else                           edge_cnt_next = edge_cnt_reg + 1'b1;
    end
  end

`ifdef FREQ_METER_AVG_EN
  localparam int AW = COUNT_WIDTH + AVG_SHIFT;
  logic [AW-1:0]        acc_reg;
  logic [AW-1:0]        acc_sum;
  logic [AVG_SHIFT-1:0] win_idx_reg;
  logic                 ovf_acc_reg;
  logic                 last_win;

  assign acc_sum  = acc_reg + AW'(edge_cnt_next);
  assign last_win = (win_idx_reg == AVG_SHIFT'(AVG_WINDOWS - 1));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      gate_cnt_reg   <= '0;
      edge_cnt_reg   <= '0;
      sat_reg        <= 1'b0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      acc_reg        <= '0;
      win_idx_reg    <= '0;
      ovf_acc_reg    <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
`ifdef FREQ_METER_AVG_EN
          acc_reg     <= '0;
          win_idx_reg <= '0;
          ovf_acc_reg <= 1'b0;
`endif
          if (start_i) begin
            state_reg      <= SETTLE;
            busy_reg       <= 1'b1;
            settle_cnt_reg <= '0;
          end
        end

        // Lets the synchronizer flush stale samples before counting begins.
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg    <= GATE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        GATE: begin
          edge_cnt_reg <= edge_cnt_next;
          sat_reg      <= sat_next;
          if (gate_cnt_reg == GATE_LAST) begin
            state_reg <= DONE;
`ifdef FREQ_METER_AVG_EN
            if (last_win) begin
              count_reg    <= COUNT_WIDTH'(acc_sum >> AVG_SHIFT);
              overflow_reg <= ovf_acc_reg | sat_next;
              valid_reg    <= 1'b1;
              acc_reg      <= '0;
              ovf_acc_reg  <= 1'b0;
              win_idx_reg  <= '0;
            end else begin
              acc_reg     <= acc_sum;
              ovf_acc_reg <= ovf_acc_reg | sat_next;
              win_idx_reg <= win_idx_reg + 1'b1;
            end
`else
            count_reg    <= edge_cnt_next;
            overflow_reg <= sat_next;
            valid_reg    <= 1'b1;
`endif
          end else begin
            gate_cnt_reg <= gate_cnt_reg + 1'b1;
          end
        end

        // Edges seen here are dropped; a restart goes straight back to GATE
        // because the synchronizer is already primed.
        DONE: begin
`ifdef FREQ_METER_AVG_EN
          if (continuous_i || (win_idx_reg != '0)) begin
`else
          if (continuous_i) begin
`endif
            state_reg    <= GATE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_reg;
  assign count_o    = count_reg;
  assign valid_o    = valid_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
// Self-checking bench for freq_meter. Two instances share clock, reset and
// the measured signal: one with a 100-cycle gate, one with a 600-cycle gate
// and an 8-bit counter for saturation. The signal is generated one value per
// reference cycle and logged; expected counts are derived from that log.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  localparam int G    = 100;
  localparam int GL   = 600;
  localparam int CW   = 8;
  localparam int S    = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef FREQ_METER_AVG_EN
  localparam int NW = 4;
`else
  localparam int NW = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  logic start_a = 1'b0, cont_a = 1'b0, start_l = 1'b0, cont_l = 1'b0;
  logic busy_a, valid_a, ovf_a, busy_l, valid_l, ovf_l;
  logic [CW-1:0] count_a, count_l;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  int per   = 4;
  int phase = 0;
  bit hist [0:131071];

  freq_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(CW), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start_a),
    .continuous_i(cont_a), .busy_o(busy_a), .count_o(count_a),
    .valid_o(valid_a), .overflow_o(ovf_a)
  );

  freq_meter #(.GATE_CYCLES(GL), .COUNT_WIDTH(CW), .SYNC_STAGES(S)) dut_long (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start_l),
    .continuous_i(cont_l), .busy_o(busy_l), .count_o(count_l),
    .valid_o(valid_l), .overflow_o(ovf_l)
  );

  always #5 clk = ~clk;

  // cyc = index of the posedge just taken; sig is constant until the next one.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (mode)
      0:       sig = 1'b0;
      1:       sig = (((cyc + phase) % per) < (per / 2));
      default: sig = 1'($urandom_range(0, 1));
    endcase
    hist[cyc] = sig;
  end

  // Rising transitions of sig become visible to the counter S cycles later.
  function automatic int edges_in(int n0, int len);
    int c = 0;
    for (int n = n0; n < n0 + len; n++)
      if (hist[n - S] && !hist[n - S - 1]) c++;
    return c;
  endfunction

  // Expected result of NW consecutive windows starting at gate cycle s.
  task automatic model(input int s, input int g, output int cnt, output bit ovf);
    int sum = 0;
    ovf = 1'b0;
    for (int w = 0; w < NW; w++) begin
      int c = edges_in(s + w * (g + 1), g);
      if (c > MAXC) begin c = MAXC; ovf = 1'b1; end
      sum += c;
    end
    cnt = sum / NW;
  endtask

  task automatic pulse_start(input bit longdut, output int k);
    @(posedge clk); #2;
    if (longdut) start_l = 1'b1; else start_a = 1'b1;
    k = cyc + 1;
    @(posedge clk); #2;
    start_l = 1'b0; start_a = 1'b0;
  endtask

  task automatic wait_valid(input bit longdut, input int limit, output int at,
                            output logic [CW-1:0] cnt, output logic ovf);
    bit got = 1'b0;
    at = -1; cnt = '0; ovf = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (longdut ? valid_l : valid_a) begin
        got = 1'b1;
        at  = cyc;
        cnt = longdut ? count_l : count_a;
        ovf = longdut ? ovf_l : ovf_a;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    total++; if (count_a !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
    total++; if ({busy_l, valid_l, ovf_l, count_l} !== '0) begin bad++; $display("FAIL reset_long: got busy=%b valid=%b ovf=%b count=%0d want all 0", busy_l, valid_l, ovf_l, count_l); end
    @(posedge clk); #2; rst = 1'b0;
    $display("reset: busy=%b valid=%b count=%0d ovf=%b", busy_a, valid_a, count_a, ovf_a);
  endtask

  task automatic test_idle_zero();
    int k, at, ecnt; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 0;
    repeat (6) @(posedge clk);
    pulse_start(1'b0, k);
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL idle_busy_rise: got %b want 1", busy_a); end
    wait_valid(1'b0, NW * (G + 1) + 50, at, cnt, ovf);
    model(k + S + 1, G, ecnt, eovf);
    total++; if (at != k + S + NW * (G + 1)) begin bad++; $display("FAIL idle_latency: got cycle %0d want %0d", at, k + S + NW * (G + 1)); end
    total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL idle_count: got %0d want %0d", cnt, ecnt); end
    total++; if (ovf !== eovf) begin bad++; $display("FAIL idle_ovf: got %b want %b", ovf, eovf); end
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy_fall: got %b want 0", busy_a); end
    $display("idle_zero: start=%0d valid_at=%0d count=%0d ovf=%b", k, at, cnt, ovf);
  endtask

  task automatic test_period4();
    int k, at, ecnt, vcount; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 1; per = 4; phase = $urandom_range(0, 9);
    pulse_start(1'b0, k);
    wait_valid(1'b0, NW * (G + 1) + 50, at, cnt, ovf);
    model(k + S + 1, G, ecnt, eovf);
    total++; if (at != k + S + NW * (G + 1)) begin bad++; $display("FAIL p4_latency: got cycle %0d want %0d", at, k + S + NW * (G + 1)); end
    total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL p4_count: got %0d want %0d", cnt, ecnt); end
    total++; if (ovf !== eovf) begin bad++; $display("FAIL p4_ovf: got %b want %b", ovf, eovf); end
    vcount = 0;
    repeat (50) begin @(negedge clk); if (valid_a) vcount++; end
    total++; if (count_a !== CW'(ecnt)) begin bad++; $display("FAIL p4_hold: got %0d want %0d", count_a, ecnt); end
    total++; if (vcount != 0) begin bad++; $display("FAIL p4_extra_valid: got %0d want 0", vcount); end
    $display("period4: phase=%0d count=%0d expect=%0d ovf=%b", phase, cnt, ecnt, ovf);
  endtask

  task automatic test_saturate();
    int k, at, ecnt; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 1; per = 2; phase = $urandom_range(0, 1);
    pulse_start(1'b1, k);
    wait_valid(1'b1, NW * (GL + 1) + 50, at, cnt, ovf);
    model(k + S + 1, GL, ecnt, eovf);
    total++; if (at != k + S + NW * (GL + 1)) begin bad++; $display("FAIL sat_latency: got cycle %0d want %0d", at, k + S + NW * (GL + 1)); end
    total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL sat_count: got %0d want %0d", cnt, ecnt); end
    total++; if (ovf !== eovf) begin bad++; $display("FAIL sat_ovf: got %b want %b", ovf, eovf); end
    $display("saturate: count=%0d expect=%0d ovf=%b expect=%b", cnt, ecnt, ovf, eovf);
  endtask

  task automatic test_random();
    int k, at, ecnt; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 2;
    for (int r = 0; r < 3; r++) begin
      pulse_start(1'b0, k);
      wait_valid(1'b0, NW * (G + 1) + 50, at, cnt, ovf);
      model(k + S + 1, G, ecnt, eovf);
      total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, cnt, ecnt); end
      total++; if (ovf !== eovf) begin bad++; $display("FAIL rand_ovf[%0d]: got %b want %b", r, ovf, eovf); end
      $display("random[%0d]: count=%0d expect=%0d", r, cnt, ecnt);
      repeat ($urandom_range(1, 20)) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int k, s, at, ecnt, vcount; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 1; per = 4; phase = $urandom_range(0, 9); cont_a = 1'b1;
    pulse_start(1'b0, k);
    s = k + S + 1;
    for (int j = 0; j < 5; j++) begin
      wait_valid(1'b0, NW * (G + 1) + 20, at, cnt, ovf);
      model(s + j * NW * (G + 1), G, ecnt, eovf);
      total++; if (at != s + (j + 1) * NW * (G + 1) - 1) begin bad++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", j, at, s + (j + 1) * NW * (G + 1) - 1); end
      total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", j, cnt, ecnt); end
      total++; if (ovf !== eovf) begin bad++; $display("FAIL b2b_ovf[%0d]: got %b want %b", j, ovf, eovf); end
      $display("back_to_back[%0d]: at=%0d count=%0d expect=%0d", j, at, cnt, ecnt);
      if (j == 1) per = 10;
      if (j == 3) begin repeat (10) @(posedge clk); #2; cont_a = 1'b0; end
    end
    vcount = 0;
    repeat (NW * (G + 1) + 10) begin @(negedge clk); if (valid_a) vcount++; end
    total++; if (vcount != 0) begin bad++; $display("FAIL b2b_stop_valid: got %0d want 0", vcount); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_reset_mid();
    int k, s, at, ecnt, vcount; bit eovf; logic [CW-1:0] cnt; logic ovf;
    mode = 1; per = 4; phase = $urandom_range(0, 9);
    pulse_start(1'b0, k);
    s = k + S + 1;
    while (cyc < s + 49) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    total++; if (count_a !== '0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count_a); end
    total++; if (ovf_a !== 1'b0 || valid_a !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got ovf=%b valid=%b want 0 0", ovf_a, valid_a); end
    vcount = 0;
    repeat (NW * (G + 1) + 20) begin @(negedge clk); if (valid_a) vcount++; end
    total++; if (vcount != 0) begin bad++; $display("FAIL rstmid_no_valid: got %0d want 0", vcount); end
    pulse_start(1'b0, k);
    wait_valid(1'b0, NW * (G + 1) + 50, at, cnt, ovf);
    model(k + S + 1, G, ecnt, eovf);
    total++; if (cnt !== CW'(ecnt)) begin bad++; $display("FAIL rstmid_restart: got %0d want %0d", cnt, ecnt); end
    $display("reset_mid: restart count=%0d expect=%0d", cnt, ecnt);
  endtask

  task automatic test_start_ignored();
    int k, s, first_at, ecnt, vcount; bit eovf; logic [CW-1:0] first_cnt;
    mode = 1; per = 4; phase = $urandom_range(0, 9);
    pulse_start(1'b0, k);
    s = k + S + 1;
    while (cyc < s + 30) @(posedge clk);
    #2; start_a = 1'b1;
    @(posedge clk); #2; start_a = 1'b0;
    vcount = 0; first_at = -1; first_cnt = '0;
    while (cyc < s + NW * (G + 1) + 150) begin
      @(negedge clk);
      if (valid_a) begin
        if (vcount == 0) begin first_at = cyc; first_cnt = count_a; end
        vcount++;
      end
    end
    model(s, G, ecnt, eovf);
    total++; if (vcount != 1) begin bad++; $display("FAIL ign_valid_count: got %0d want 1", vcount); end
    total++; if (first_at != s + NW * (G + 1) - 1) begin bad++; $display("FAIL ign_timing: got cycle %0d want %0d", first_at, s + NW * (G + 1) - 1); end
    total++; if (first_cnt !== CW'(ecnt)) begin bad++; $display("FAIL ign_count: got %0d want %0d", first_cnt, ecnt); end
    $display("start_ignored: valids=%0d count=%0d expect=%0d", vcount, first_cnt, ecnt);
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_period4();
    test_saturate();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
